// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM states and byte-enable masks for the MEM stage
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [3:0] BE_B  = 4'b0001;
    localparam logic [3:0] BE_H  = 4'b0011;
    localparam logic [3:0] BE_W  = 4'b1111;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half from a read word and sign- or zero-extends it
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b    = 8'(rdata >> {offset, 3'b000});
        h    = 16'(rdata >> {offset, 3'b000});
        data = funct3 == F3_B  ? {{24{b[7]}}, b}
             : funct3 == F3_BU ? {24'b0, b}
             : funct3 == F3_H  ? {{16{h[15]}}, h}
             : funct3 == F3_HU ? {16'b0, h}
             : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns RV32I loads/stores into valid/ready data-memory transactions with stall and timeout
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_valid,
    input  logic        M_mem_r,
    input  logic        M_mem_w,
    input  logic [2:0]  M_funct3,
    input  logic [31:0] M_alu_out,
    input  logic [31:0] M_rs2_data,
    output logic        dm_req,
    input  logic        dm_ready,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err,
    output logic [31:0] W_ld_data
);
    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        is_ld;
    logic        aligned, legal, start, busy, st_done, ld_done, tmo;
    logic [3:0]  we_nx;
    logic [31:0] wdata_nx, ext;

    load_extend u_ext (
        .funct3(ld_f3),
        .offset(ld_off),
        .rdata (dm_rdata),
        .data  (ext)
    );

    always_comb begin
        aligned  = M_funct3[1:0] == 2'b10 ? M_alu_out[1:0] == 2'b00
                 : M_funct3[0] ? !M_alu_out[0] : 1'b1;
        legal    = M_funct3[1:0] != 2'b11 && !(M_funct3[2] && (M_funct3[1] || M_mem_w));
        start    = state == IDLE && M_valid && (M_mem_r ^ M_mem_w) && aligned && legal;
        busy     = state != IDLE;
        st_done  = state == REQ && dm_ready && !is_ld;
        ld_done  = state == RESP && dm_rvalid;
        tmo      = busy && cnt == 16'(TIMEOUT_CYCLES - 1) && !st_done && !ld_done;
        we_nx    = M_mem_r ? 4'b0000
                 : 4'((M_funct3[1:0] == 2'b00 ? BE_B : M_funct3[0] ? BE_H : BE_W) << M_alu_out[1:0]);
        wdata_nx = M_funct3[1:0] == 2'b00 ? {4{M_rs2_data[7:0]}}
                 : M_funct3[0] ? {2{M_rs2_data[15:0]}} : M_rs2_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? REQ : IDLE)
                 : tmo ? IDLE
                 : state == REQ ? (dm_ready ? (is_ld ? RESP : IDLE) : REQ)
                 : dm_rvalid ? IDLE : RESP;
    end

    // the timeout cycle releases the stall so the faulting instruction leaves MEM instead of restarting
    always_comb begin
        dm_req       = state == REQ;
        mem_misalign = state == IDLE && M_valid && (M_mem_r || M_mem_w) && !start;
        mem_stall    = start
                    || (state == REQ && !st_done && !tmo)
                    || (state == RESP && !dm_rvalid && !tmo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_addr     <= '0;
            dm_we       <= '0;
            dm_wdata    <= '0;
            ld_f3       <= '0;
            ld_off      <= '0;
            is_ld       <= 1'b0;
            cnt         <= '0;
            W_ld_data   <= '0;
            mem_bus_err <= 1'b0;
        end else begin
            mem_bus_err <= tmo;
            cnt         <= start ? 16'd0 : busy ? cnt + 16'd1 : cnt;
            if (start) begin
                dm_addr  <= {M_alu_out[31:2], 2'b00};
                dm_we    <= we_nx;
                dm_wdata <= wdata_nx;
                ld_f3    <= M_funct3;
                ld_off   <= M_alu_out[1:0];
                is_ld    <= M_mem_r;
            end
            if (ld_done)
                W_ld_data <= ext;
            else if (tmo && is_ld)
                W_ld_data <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of store lanes, load extension, misalign, timeout and reset abort
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid, M_mem_r, M_mem_w;
    logic [2:0]  M_funct3;
    logic [31:0] M_alu_out, M_rs2_data;
    logic        dm_ready, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        d_req, d_stall, d_mis, d_err;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, d_ld;
    logic        t_req, t_stall, t_mis, t_err;
    logic [3:0]  t_we;
    logic [31:0] t_addr, t_wdata, t_ld;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .M_valid(M_valid), .M_mem_r(M_mem_r), .M_mem_w(M_mem_w),
        .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
        .dm_req(d_req), .dm_ready(dm_ready), .dm_we(d_we), .dm_addr(d_addr), .dm_wdata(d_wdata),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_stall(d_stall), .mem_misalign(d_mis),
        .mem_bus_err(d_err), .W_ld_data(d_ld)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .M_valid(M_valid), .M_mem_r(M_mem_r), .M_mem_w(M_mem_w),
        .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
        .dm_req(t_req), .dm_ready(dm_ready), .dm_we(t_we), .dm_addr(t_addr), .dm_wdata(t_wdata),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_stall(t_stall), .mem_misalign(t_mis),
        .mem_bus_err(t_err), .W_ld_data(t_ld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        M_valid = v; M_mem_r = r; M_mem_w = w; M_funct3 = f3; M_alu_out = a; M_rs2_data = d;
    endtask

    task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_we, input logic [31:0] exp_wd);
        set_m(1, 0, 1, f3, a, d);
        #1;
        chk({tag, " start stall"}, 32'(d_stall), 1);
        chk({tag, " start req"}, 32'(d_req), 0);
        tick;
        dm_ready = 1;
        #1;
        chk({tag, " req"}, 32'(d_req), 1);
        chk({tag, " addr"}, d_addr, {a[31:2], 2'b00});
        chk({tag, " we"}, 32'(d_we), 32'(exp_we));
        chk({tag, " wdata"}, d_wdata, exp_wd);
        chk({tag, " release stall"}, 32'(d_stall), 0);
        tick;
        dm_ready = 0;
        M_valid = 0;
        #1;
        chk({tag, " idle req"}, 32'(d_req), 0);
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input int rw, input int vw, input logic [31:0] exp);
        int stalls = 0;
        set_m(1, 1, 0, f3, a, 32'h0);
        dm_rdata = rd;
        #1;
        stalls += int'(d_stall);
        tick;
        repeat (rw) begin
            stalls += int'(d_stall);
            tick;
        end
        dm_ready = 1;
        #1;
        chk({tag, " req"}, 32'(d_req), 1);
        chk({tag, " we"}, 32'(d_we), 0);
        stalls += int'(d_stall);
        tick;
        dm_ready = 0;
        repeat (vw) begin
            stalls += int'(d_stall);
            tick;
        end
        dm_rvalid = 1;
        #1;
        chk({tag, " release stall"}, 32'(d_stall), 0);
        stalls += int'(d_stall);
        tick;
        dm_rvalid = 0;
        M_valid = 0;
        #1;
        chk({tag, " data"}, d_ld, exp);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(rw + vw + 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dm_ready = 0; dm_rvalid = 0; dm_rdata = 0;
        set_m(0, 0, 0, 3'b000, 0, 0);
        tick;
        tick;
        chk("rst req", 32'(d_req), 0);
        chk("rst we", 32'(d_we), 0);
        chk("rst addr", d_addr, 0);
        chk("rst wdata", d_wdata, 0);
        chk("rst ld", d_ld, 0);
        chk("rst err", 32'(d_err), 0);
        chk("rst stall", 32'(d_stall), 0);
        rst = 0;
        tick;

        store_op("SW", 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        store_op("SB", 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
        store_op("SH", 3'b001, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);

        load_op("LB", 3'b000, 32'h201, 32'h00008000, 3, 2, 32'hFFFFFF80);
        load_op("LBU", 3'b100, 32'h201, 32'h00008000, 3, 2, 32'h00000080);
        load_op("LW", 3'b010, 32'h204, 32'h12345678, 0, 0, 32'h12345678);

        set_m(1, 1, 0, 3'b001, 32'h203, 0);
        #1;
        chk("LH odd misalign", 32'(d_mis), 1);
        chk("LH odd stall", 32'(d_stall), 0);
        tick;
        chk("LH odd no req", 32'(d_req), 0);
        set_m(1, 1, 1, 3'b010, 32'h200, 0);
        #1;
        chk("r&w misalign", 32'(d_mis), 1);
        set_m(1, 0, 1, 3'b100, 32'h200, 0);
        #1;
        chk("store f3 1xx misalign", 32'(d_mis), 1);
        set_m(1, 1, 0, 3'b011, 32'h200, 0);
        #1;
        chk("f3 011 misalign", 32'(d_mis), 1);
        tick;
        chk("illegal no req", 32'(d_req), 0);
        M_valid = 0;

        rst = 1;
        tick;
        rst = 0;
        load_op("LW pre-timeout", 3'b010, 32'h300, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D);
        chk("TO pre data", t_ld, 32'hCAFEF00D);
        set_m(1, 1, 0, 3'b010, 32'h304, 0);
        #1;
        chk("TO start stall", 32'(t_stall), 1);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("TO req held", 32'(t_req), 1);
            chk("TO stall held", 32'(t_stall), 1);
            chk("TO no err yet", 32'(t_err), 0);
            tick;
        end
        chk("TO last req", 32'(t_req), 1);
        chk("TO last stall", 32'(t_stall), 0);
        tick;
        M_valid = 0;
        #1;
        chk("TO err pulse", 32'(t_err), 1);
        chk("TO req dropped", 32'(t_req), 0);
        chk("TO stall", 32'(t_stall), 0);
        chk("TO ld zero", t_ld, 0);
        dm_rvalid = 1;
        dm_rdata = 32'h55;
        tick;
        dm_rvalid = 0;
        chk("TO err single", 32'(t_err), 0);
        chk("TO late rvalid ignored", t_ld, 0);
        chk("TO idle", 32'(t_req), 0);

        rst = 1;
        tick;
        rst = 0;
        set_m(1, 1, 0, 3'b010, 32'h400, 0);
        tick;
        dm_ready = 1;
        tick;
        dm_ready = 0;
        #1;
        chk("RESP wait stall", 32'(d_stall), 1);
        rst = 1;
        M_valid = 0;
        tick;
        rst = 0;
        #1;
        chk("mid rst req", 32'(d_req), 0);
        chk("mid rst stall", 32'(d_stall), 0);
        chk("mid rst addr", d_addr, 0);
        chk("mid rst err", 32'(d_err), 0);
        dm_rvalid = 1;
        dm_rdata = 32'hFFFFFFFF;
        tick;
        dm_rvalid = 0;
        chk("mid rst late rvalid", d_ld, 0);
        load_op("LH", 3'b001, 32'h402, 32'h80011234, 1, 1, 32'hFFFF8001);
        load_op("LHU", 3'b101, 32'h402, 32'h80011234, 0, 1, 32'h00008001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
